// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: raw active-low key in, conditioned events out.
// The conditioner takes the slave view; the board/bench side takes the master view.
interface key_conditioner_if;
  logic key_n;
  logic pulse;
  logic held;
  logic repeating;

  modport master (output key_n, input pulse, input held, input repeating);
  modport slave  (input key_n, output pulse, output held, output repeating);
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, press/release debounce, one pulse per press
// plus optional auto-repeat pulses while held.
//
// state          | meaning
// ---------------|-----------------------------------------------------------
// S_IDLE         | key released and debounced; waiting for key_s low
// S_PRESS_WAIT   | key_s low; counting toward an accepted press
// S_HOLD         | press accepted; counting the initial repeat delay
// S_REPEAT       | auto-repeating; pulse every REPEAT_PERIOD cycles
// S_RELEASE_WAIT | key_s high while held; counting toward an accepted release
module key_conditioner #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  key_conditioner_if.slave kif
);

  localparam int MAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_C);

  localparam logic [CW-1:0] DEB_TC  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] RD_TC   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_TC   = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HOLD,
    S_REPEAT,
    S_RELEASE_WAIT
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      sync_q;
  logic            key_s;
  logic            pulse_q, held_q, rep_q;
  logic            pulse_nxt, held_nxt, rep_nxt;

  assign key_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], kif.key_n};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pulse_q <= pulse_nxt;
      held_q  <= held_nxt;
      rep_q   <= rep_nxt;
    end
  end

  // A key_s change always takes priority over a terminal count in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!key_s) state_nxt = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        if (key_s)              state_nxt = S_IDLE;
        else if (cnt == DEB_TC) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (key_s) begin
          state_nxt = S_RELEASE_WAIT;
        end else if (REPEAT_EN) begin
          if (cnt == RD_TC) state_nxt = S_REPEAT;
        end else if (cnt == CNT_MAX) begin
          cnt_nxt = cnt;
        end
      end
      S_REPEAT: begin
        if (key_s)             state_nxt = S_RELEASE_WAIT;
        else if (cnt == RP_TC) cnt_nxt = '0;
      end
      S_RELEASE_WAIT: begin
        if (!key_s)             state_nxt = S_HOLD;
        else if (cnt == DEB_TC) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_comb begin
    pulse_nxt = 1'b0;
    if (state == S_PRESS_WAIT && state_nxt == S_HOLD) pulse_nxt = 1'b1;
    if (state == S_HOLD && state_nxt == S_REPEAT)     pulse_nxt = 1'b1;
    if (state == S_REPEAT && state_nxt == S_REPEAT && cnt == RP_TC) pulse_nxt = 1'b1;
    held_nxt = (state_nxt == S_HOLD) || (state_nxt == S_REPEAT) ||
               (state_nxt == S_RELEASE_WAIT);
    rep_nxt  = (state_nxt == S_REPEAT);
  end

  assign kif.pulse     = pulse_q;
  assign kif.held      = held_q;
  assign kif.repeating = rep_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length reference model of the debounce/repeat
// rules, directed scenarios and randomized key traffic on two instances.
module tb_key_conditioner;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  key_conditioner_if ifa ();
  key_conditioner_if ifb ();

  key_conditioner #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .REPEAT_EN(1'b1)) dut_a (.clk(clk), .rst(rst), .kif(ifa.slave));
  key_conditioner #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                    .REPEAT_EN(1'b0)) dut_b (.clk(clk), .rst(rst), .kif(ifb.slave));

  typedef struct {
    logic h1;
    logic h2;
    bit   held;
    bit   rep;
    bit   pulse;
    int   zrun;
    int   orun;
    int   anchor;
  } model_t;

  model_t ma, mb;
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  function automatic model_t mreset();
    model_t m;
    m.h1 = 1'b1; m.h2 = 1'b1;
    m.held = 0; m.rep = 0; m.pulse = 0;
    m.zrun = 0; m.orun = 0; m.anchor = 0;
    return m;
  endfunction

  // s is the key level the debouncer sees at edge t: key_n sampled two edges earlier.
  // A press needs DEB+1 consecutive low looks, a release DEB+1 consecutive high looks.
  function automatic model_t mstep(model_t m, logic kn, bit ren, int t);
    logic s;
    s = m.h2;
    m.h2 = m.h1;
    m.h1 = kn;
    m.pulse = 0;
    if (!m.held) begin
      if (s == 1'b0) begin
        m.zrun++;
        if (m.zrun == DEB + 1) begin
          m.held = 1; m.pulse = 1; m.anchor = t; m.zrun = 0; m.orun = 0;
        end
      end else begin
        m.zrun = 0;
      end
    end else if (s == 1'b1) begin
      m.rep = 0;
      m.orun++;
      if (m.orun == DEB + 1) begin
        m.held = 0; m.orun = 0;
      end
    end else if (m.orun > 0) begin
      m.orun = 0; m.anchor = t;
    end else if (ren && !m.rep && (t - m.anchor) == RD) begin
      m.pulse = 1; m.rep = 1; m.anchor = t;
    end else if (m.rep && (t - m.anchor) == RP) begin
      m.pulse = 1; m.anchor = t;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      ma = mstep(ma, ifa.key_n, 1'b1, cyc);
      mb = mstep(mb, ifb.key_n, 1'b0, cyc);
    end else begin
      ma = mreset();
      mb = mreset();
    end
  endtask

  task automatic settle();
    ifa.key_n = 1'b1;
    ifb.key_n = 1'b1;
    for (int i = 0; i < 3 * DEB; i++) tick();
  endtask

  task automatic test_reset();
    ifa.key_n = 1'b0;
    ifb.key_n = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_checks++;
    if ({ifa.pulse, ifa.held, ifa.repeating} !== 3'b000)
      $display("FAIL reset_a outputs got %b required 000", {ifa.pulse, ifa.held, ifa.repeating});
    else n_pass++;
    n_checks++;
    if ({ifb.pulse, ifb.held, ifb.repeating} !== 3'b000)
      $display("FAIL reset_b outputs got %b required 000", {ifb.pulse, ifb.held, ifb.repeating});
    else n_pass++;
    ifa.key_n = 1'b1;
    ifb.key_n = 1'b1;
    rst = 1'b1;
    settle();
  endtask

  task automatic test_clean_press();
    int k, pulses, pcyc, fall;
    pulses = 0; pcyc = -1; fall = -1;
    k = cyc + 1;
    ifa.key_n = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (i == 12) ifa.key_n = 1'b1;
      tick();
      if (ifa.pulse) begin pulses++; pcyc = cyc; end
      if (fall < 0 && cyc > k + 6 && !ifa.held) fall = cyc;
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL clean_press cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
    end
    n_checks++;
    if (pulses != 1 || pcyc != k + 6)
      $display("FAIL clean_press_pulse got %0d pulses at k+%0d required 1 at k+6", pulses, pcyc - k);
    else n_pass++;
    n_checks++;
    if (fall != k + 12 + 6)
      $display("FAIL clean_press_release held fell at k+%0d required k+18", fall - k);
    else n_pass++;
    settle();
  endtask

  task automatic test_press_bounce();
    logic pat [0:7];
    bit seen;
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      ifa.key_n = (i < 8) ? pat[i] : 1'b1;
      tick();
      if (ifa.pulse || ifa.held) seen = 1;
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL press_bounce cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
    end
    n_checks++;
    if (seen) $display("FAIL press_bounce_quiet got pulse/held activity required none");
    else n_pass++;
  endtask

  task automatic test_long_hold();
    int k, first_rep;
    int q[$];
    int exp_off [0:5];
    exp_off = '{6, 26, 34, 42, 50, 58};
    first_rep = -1;
    k = cyc + 1;
    ifa.key_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ifa.pulse) q.push_back(cyc - k);
      if (first_rep < 0 && ifa.repeating) first_rep = cyc - k;
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL long_hold cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 6) $display("FAIL long_hold_count got %0d pulses required 6", q.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      n_checks++;
      if (q[i] != exp_off[i])
        $display("FAIL long_hold_pulse%0d got k+%0d required k+%0d", i, q[i], exp_off[i]);
      else n_pass++;
    end
    n_checks++;
    if (first_rep != 26) $display("FAIL long_hold_repeating got k+%0d required k+26", first_rep);
    else n_pass++;
    settle();
  endtask

  // First high sample lands on edge k+32 so the release is seen exactly when
  // the k+34 repeat pulse is due; HOLD is re-entered at k+36.
  task automatic test_release_glitch();
    int k;
    int q[$];
    k = cyc + 1;
    ifa.key_n = 1'b0;
    for (int i = 0; i < 62; i++) begin
      if (cyc + 1 == k + 32 || cyc + 1 == k + 33) ifa.key_n = 1'b1;
      else ifa.key_n = 1'b0;
      tick();
      if (ifa.pulse && cyc > k + 26) q.push_back(cyc - k);
      if (cyc == k + 36) begin
        n_checks++;
        if ({ifa.held, ifa.repeating} !== 2'b10)
          $display("FAIL glitch_rehold got h/r=%b required 10", {ifa.held, ifa.repeating});
        else n_pass++;
      end
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL release_glitch cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
    end
    n_checks++;
    if (q.size() != 1 || q[0] != 56)
      $display("FAIL glitch_next_pulse got %0d pulses first at k+%0d required 1 at k+56",
               q.size(), (q.size() > 0) ? q[0] : -1);
    else n_pass++;
    settle();
  endtask

  task automatic test_repeat_disabled();
    int k, pulses, pcyc;
    pulses = 0; pcyc = -1;
    k = cyc + 1;
    ifb.key_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ifb.pulse) begin pulses++; pcyc = cyc; end
      n_checks++;
      if ({ifb.pulse, ifb.held, ifb.repeating} !== {mb.pulse, mb.held, mb.rep})
        $display("FAIL repeat_disabled cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifb.pulse, ifb.held, ifb.repeating}, {mb.pulse, mb.held, mb.rep});
      else n_pass++;
    end
    n_checks++;
    if (pulses != 1 || pcyc != k + 6)
      $display("FAIL repeat_disabled_pulse got %0d pulses last at k+%0d required 1 at k+6",
               pulses, pcyc - k);
    else n_pass++;
    settle();
  endtask

  task automatic test_reset_mid_hold();
    int k, pcyc;
    pcyc = -1;
    ifa.key_n = 1'b0;
    for (int i = 0; i < 32; i++) tick();
    n_checks++;
    if (ifa.repeating !== 1'b1) $display("FAIL mid_hold_precond repeating got %b required 1", ifa.repeating);
    else n_pass++;
    #2;
    rst = 1'b0;
    ma = mreset();
    mb = mreset();
    #1;
    n_checks++;
    if ({ifa.pulse, ifa.held, ifa.repeating} !== 3'b000)
      $display("FAIL async_reset got p/h/r=%b required 000", {ifa.pulse, ifa.held, ifa.repeating});
    else n_pass++;
    tick();
    tick();
    rst = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifa.pulse && pcyc < 0) pcyc = cyc;
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL reset_mid_hold cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
    end
    n_checks++;
    if (pcyc != k + 6) $display("FAIL reset_relaunch pulse at k+%0d required k+6", pcyc - k);
    else n_pass++;
    settle();
  endtask

  task automatic test_random();
    int run_a, run_b;
    run_a = 0; run_b = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_a == 0) begin
        ifa.key_n = ~ifa.key_n;
        run_a = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      end
      if (run_b == 0) begin
        ifb.key_n = ~ifb.key_n;
        run_b = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
      end
      run_a--;
      run_b--;
      tick();
      n_checks++;
      if ({ifa.pulse, ifa.held, ifa.repeating} !== {ma.pulse, ma.held, ma.rep})
        $display("FAIL random_a cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifa.pulse, ifa.held, ifa.repeating}, {ma.pulse, ma.held, ma.rep});
      else n_pass++;
      n_checks++;
      if ({ifb.pulse, ifb.held, ifb.repeating} !== {mb.pulse, mb.held, mb.rep})
        $display("FAIL random_b cyc=%0d got p/h/r=%b required %b", cyc,
                 {ifb.pulse, ifb.held, ifb.repeating}, {mb.pulse, mb.held, mb.rep});
      else n_pass++;
    end
    settle();
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    ifa.key_n = 1'b1;
    ifb.key_n = 1'b1;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_long_hold();
    test_release_glitch();
    test_repeat_disabled();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Conditions one raw, active-low push-button input (the `add` or `nextP` key) into clean single-cycle event pulses for the clock's set-mode logic. The block performs three jobs:
- synchronises the asynchronous pin;
- debounces press and release;
- emits one pulse per press, plus optional auto-repeat pulses while the key is held.

One instance sits between each board button and the clock top level, so holding `add` steps the selected field at a steady rate.

## Interface
- `DEB_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a press or a release (20 ms at 50 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 25_000_000: held cycles from the first pulse to the first repeat pulse. Must be ≥ 2.
- `REPEAT_PERIOD`, default 5_000_000: cycles between successive repeat pulses. Must be ≥ 2.
- `REPEAT_EN`, default 1: 1 enables auto-repeat; 0 gives one pulse per press only.

Ports:
- `clk` in, 1 bit: system clock; the only clock.
- `rst` in, 1 bit: asynchronous, active-low reset.
- `key_n` in, 1 bit: raw button; 0 = pressed; asynchronous to `clk`.
- `pulse` out, 1 bit: registered; high for exactly one cycle per accepted press and per repeat.
- `held` out, 1 bit: registered; debounced pressed level.
- `repeating` out, 1 bit: registered; high while in REPEAT.

## Operation
**Synchroniser**
- Two-flop synchroniser on `key_n` produces `key_s`.
- Both flops reset to 1 (released).

**Counter**
- One shared counter `cnt`.
- Width = clog2 of max(`DEB_CYCLES`, `REPEAT_DELAY`, `REPEAT_PERIOD`).
- Cleared on every state transition.

**FSM states:** IDLE, PRESS_WAIT, HOLD, REPEAT, RELEASE_WAIT.

**IDLE**
- `key_s`=0 → PRESS_WAIT.

**PRESS_WAIT**
- `key_s`=1 → IDLE, no pulse (bounce rejected).
- Otherwise `cnt`++.
- At `cnt`==`DEB_CYCLES`-1 with `key_s`=0 → HOLD; `pulse`=1 and `held`=1 are registered on that edge.

**HOLD**
- `key_s`=1 → RELEASE_WAIT.
- Otherwise `cnt`++.
- If `REPEAT_EN`=1 and `cnt`==`REPEAT_DELAY`-1 → REPEAT with `pulse`=1.
- If `REPEAT_EN`=0, `cnt` saturates; the block never leaves HOLD except via release.

**REPEAT**
- `key_s`=1 → RELEASE_WAIT.
- Otherwise `cnt`++.
- At `cnt`==`REPEAT_PERIOD`-1: `pulse`=1, `cnt`=0, stay in REPEAT.

**RELEASE_WAIT**
- `key_s`=0 → HOLD, `cnt`=0, no pulse. The repeat delay restarts and `repeating` drops.
- Otherwise `cnt`++.
- At `cnt`==`DEB_CYCLES`-1 → IDLE; `held`=0 registered on that edge.

**Output rules**
- `held`=1 in HOLD, REPEAT and RELEASE_WAIT.
- `repeating`=1 only in REPEAT.
- `pulse` is never high on two consecutive cycles.

## Timing
**Reset**
- Asserting `rst` at any time, including mid-press or mid-repeat, immediately forces: state IDLE, `cnt`=0, `pulse`=0, `held`=0, `repeating`=0, sync flops = 1.
- After reset release, a key that is already held must complete the full synchroniser + debounce sequence before it produces a pulse.

**Latency.** Let edge k be the first rising edge at which the first sync flop captures `key_n`=0.
- `key_s`=0 after edge k+1.
- PRESS_WAIT is entered at edge k+2.
- `pulse` and `held` rise at edge k+2+`DEB_CYCLES`.
- The first repeat pulse follows `REPEAT_DELAY` edges later.
- Subsequent repeat pulses follow every `REPEAT_PERIOD` edges.

**Release**
- `held` falls `DEB_CYCLES`+2 edges after the first sampled `key_n`=1, provided no glitch back to 0 occurs.

**Simultaneous events**
- A release seen in the same cycle a repeat pulse is due: release wins, no pulse.
- A bounce seen in the same cycle debounce would complete: bounce wins, no transition.

## Test plan
All scenarios use `DEB_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `REPEAT_EN`=1 unless stated.

1. **Clean press.** `key_n` low for 12 cycles, then high. Required:
   - one `pulse` at edge k+6;
   - `held` high from k+6;
   - `held` low 6 edges after the first high sample;
   - `repeating` stays 0.
2. **Press bounce.** `key_n` pattern 0,0,0,1,0,0,1,1… Required: no `pulse`; `held` stays 0.
3. **Long hold.** `key_n` low for 60 cycles. Required:
   - pulses at k+6, k+26, k+34, k+42, k+50, k+58;
   - `repeating` high from k+26.
4. **Release glitch.** During REPEAT, `key_n` goes high for 2 cycles, then low again. Required:
   - return to HOLD, no pulse, `repeating`=0;
   - next pulse 20 edges after re-entry to HOLD.
5. **Repeat disabled.** `REPEAT_EN`=0, `key_n` low for 60 cycles. Required: exactly one pulse, at k+6.
6. **Reset mid-hold.** Pull `rst` low while in REPEAT. Required:
   - all outputs 0 asynchronously;
   - after `rst` rises with `key_n` still low, a pulse 6 edges after the first sync capture.
